// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data accesses.
// Data has fixed priority; each access runs ISSUE -> WAIT (WAIT+1 cycles) -> RESP.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned WAIT   = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_abort_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_ack_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_if_o,
    output logic              stall_mem_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    localparam logic [2:0] WaitCnt = 3'(WAIT);

    state_e            state_q;
    logic [2:0]        cnt_q;
    logic              owner_q;  // 1 = data, 0 = fetch
    logic              we_q;
    logic              killed_q;
    logic              if_ack_q;
    logic              d_ack_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= 3'd0;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            killed_q    <= 1'b0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (d_req_i) begin
                        owner_q     <= 1'b1;
                        we_q        <= d_we_i;
                        mem_addr_q  <= d_addr_i;
                        mem_wdata_q <= d_wdata_i;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= d_we_i;
                        state_q     <= StIssue;
                    end else if (if_req_i && !if_abort_i) begin
                        owner_q    <= 1'b0;
                        we_q       <= 1'b0;
                        mem_addr_q <= if_addr_i;
                        mem_en_q   <= 1'b1;
                        mem_we_q   <= 1'b0;
                        state_q    <= StIssue;
                    end
                end
                StIssue: begin
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    cnt_q    <= WaitCnt;
                    if (!owner_q && if_abort_i) killed_q <= 1'b1;
                    state_q  <= StWait;
                end
                StWait: begin
                    if (!owner_q && if_abort_i) killed_q <= 1'b1;
                    if (cnt_q == 3'd0) begin
                        if (owner_q && !we_q) d_rdata_q <= mem_rdata_i;
                        if (!owner_q) if_rdata_q <= mem_rdata_i;
                        d_ack_q  <= owner_q;
                        // A flush landing on the last WAIT cycle must also suppress the ack.
                        if_ack_q <= !owner_q && !killed_q && !if_abort_i;
                        state_q  <= StResp;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                StResp: begin
                    d_ack_q  <= 1'b0;
                    if_ack_q <= 1'b0;
                    killed_q <= 1'b0;
                    state_q  <= StIdle;
                end
            endcase
        end
    end

    assign if_ack_o    = if_ack_q && !if_abort_i;
    assign d_ack_o     = d_ack_q;
    assign if_rdata_o  = if_rdata_q;
    assign d_rdata_o   = d_rdata_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign busy_o      = (state_q != StIdle);
    assign stall_mem_o = d_req_i && !d_ack_o;
    assign stall_if_o  = if_req_i && !if_ack_o && !if_abort_i;

endmodule
